// File: rtl/clock_fpla.sv
// Horizontal-timing decoder: extends the 8-bit pixel count with an internal 256H bit and decodes line strobes.
// Optional CLOCK_FPLA_REGOUT_EN registers all outputs on MCKR (one cycle of extra latency).
module clock_fpla (
    input  logic       MCKR,
    input  logic       rst_b,
    input  logic [7:0] in,
    output logic [9:0] out
);

    localparam logic [9:0] RESET_OUT = 10'b1_000_1_1_0_1_1_0;

    logic       r_h256;
    logic [8:0] w_h;
    logic       w_active;
    logic [9:0] w_dec;

    // The upstream counter wraps on the same edge, so toggling on a sampled 8'hFF keeps h glitch-free.
    always_ff @(posedge MCKR or negedge rst_b) begin
        if (!rst_b) begin
            r_h256 <= 1'b0;
        end else if (in == 8'hFF) begin
            r_h256 <= ~r_h256;
        end
    end

    assign w_h      = {r_h256, in};
    assign w_active = (w_h < 9'd336);

    always_comb begin
        w_dec      = RESET_OUT;
        w_dec[9]   = (w_h != 9'd511);
        w_dec[8:6] = w_active ? in[2:0] : 3'b111;
        w_dec[5]   = (w_h != 9'd504);
        w_dec[4]   = w_active;
        w_dec[3]   = (w_h >= 9'd376) && (w_h <= 9'd407);
        w_dec[2]   = !((in[2:0] == 3'b111) && w_active);
        w_dec[1]   = !((w_h >= 9'd336) && (w_h <= 9'd503));
        w_dec[0]   = r_h256;
    end

`ifdef CLOCK_FPLA_REGOUT_EN
    logic [9:0] r_out;

    always_ff @(posedge MCKR or negedge rst_b) begin
        if (!rst_b) begin
            r_out <= RESET_OUT;
        end else begin
            r_out <= w_dec;
        end
    end

    assign out = r_out;
`else
    assign out = w_dec;
`endif

endmodule

// File: tb/tb_clock_fpla.sv
// Directed bench for clock_fpla: table of hand-decoded positions checked during a full-line sweep,
// plus reset, 256H wrap and mid-line asynchronous reset sequences.
module tb_clock_fpla;

    logic       MCKR = 1'b0;
    logic       rst_b = 1'b0;
    logic [7:0] in = 8'h00;
    logic [9:0] out;

`ifdef CLOCK_FPLA_REGOUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    clock_fpla dut (
        .MCKR (MCKR),
        .rst_b(rst_b),
        .in   (in),
        .out  (out)
    );

    always #5 MCKR = ~MCKR;

    typedef struct {
        int         h;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl[17];
    int   checks = 0;
    int   errors = 0;
    logic m_h256 = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic step(input logic [7:0] v);
        @(posedge MCKR);
        if (rst_b && in == 8'hFF) m_h256 = ~m_h256;
        #1 in = v;
        @(negedge MCKR);
    endtask

    initial begin
        int h_cur, h_prev, h_obs;
        int hbl_hi, hs_hi, hs_first, hs_last, buf_lo, lmpd_lo, lmpd_h, nxl_lo, nxl_h, pf_lo;
        int pf_bad, vrac_bad;
        logic exp_pf;
        logic [2:0] exp_vrac;

        // {h, NXL_b, VRAC[2:0], LMPD_b, HBLANK_b, HSYNC, PFHST_b, BUFCLR_b, SC_256H}
        tbl[0]  = '{0,   10'b1_000_1_1_0_1_1_0};
        tbl[1]  = '{5,   10'b1_101_1_1_0_1_1_0};
        tbl[2]  = '{7,   10'b1_111_1_1_0_0_1_0};
        tbl[3]  = '{8,   10'b1_000_1_1_0_1_1_0};
        tbl[4]  = '{255, 10'b1_111_1_1_0_0_1_0};
        tbl[5]  = '{256, 10'b1_000_1_1_0_1_1_1};
        tbl[6]  = '{300, 10'b1_100_1_1_0_1_1_1};
        tbl[7]  = '{335, 10'b1_111_1_1_0_0_1_1};
        tbl[8]  = '{336, 10'b1_111_1_0_0_1_0_1};
        tbl[9]  = '{375, 10'b1_111_1_0_0_1_0_1};
        tbl[10] = '{376, 10'b1_111_1_0_1_1_0_1};
        tbl[11] = '{407, 10'b1_111_1_0_1_1_0_1};
        tbl[12] = '{408, 10'b1_111_1_0_0_1_0_1};
        tbl[13] = '{503, 10'b1_111_1_0_0_1_0_1};
        tbl[14] = '{504, 10'b1_111_0_0_0_1_1_1};
        tbl[15] = '{510, 10'b1_111_1_0_0_1_1_1};
        tbl[16] = '{511, 10'b0_111_1_0_0_1_1_1};

        // Reset: outputs decode {0,in}; 8'hFF under reset must not toggle 256H
        #2;
        chk("reset_out_in0", int'(out), int'(10'b1_000_1_1_0_1_1_0));
        in = 8'hFF;
        repeat (3) @(posedge MCKR);
        @(negedge MCKR);
        chk("reset_out_inFF", int'(out), LAT ? int'(10'b1_000_1_1_0_1_1_0) : int'(10'b1_111_1_1_0_0_1_0));
        in = 8'h00;
        @(negedge MCKR);
        rst_b = 1'b1;
        #1;
        chk("release_out", int'(out), int'(10'b1_000_1_1_0_1_1_0));

        h_prev = 0; hbl_hi = 0; hs_hi = 0; hs_first = -1; hs_last = -1; buf_lo = 0;
        lmpd_lo = 0; lmpd_h = -1; nxl_lo = 0; nxl_h = -1; pf_lo = 0; pf_bad = 0; vrac_bad = 0;

        // Full line plus one wrap back to h=0
        for (int i = 0; i <= 512; i++) begin
            if (i > 0) step(8'(i));
            h_cur = {23'd0, m_h256, in};
            h_obs = (LAT != 0) ? h_prev : h_cur;
            for (int k = 0; k < 17; k++)
                if (tbl[k].h == h_obs && !(i == 512 && k != 0))
                    chk($sformatf("tbl_h%0d_i%0d", h_obs, i), int'(out), int'(tbl[k].exp));
            if (i >= LAT && i <= 511 + LAT) begin
                if (out[4]) hbl_hi++;
                if (out[3]) begin
                    hs_hi++;
                    if (hs_first < 0) hs_first = h_obs;
                    hs_last = h_obs;
                end
                if (!out[1]) buf_lo++;
                if (!out[5]) begin lmpd_lo++; lmpd_h = h_obs; end
                if (!out[9]) begin nxl_lo++; nxl_h = h_obs; end
                if (!out[2]) pf_lo++;
                exp_pf   = !((h_obs % 8 == 7) && (h_obs < 336));
                exp_vrac = (h_obs < 336) ? 3'(h_obs % 8) : 3'b111;
                if (out[2] != exp_pf) pf_bad++;
                if (out[8:6] != exp_vrac) vrac_bad++;
            end
            h_prev = h_cur;
        end

        chk("hblank_high_count", hbl_hi, 336);
        chk("hsync_high_count", hs_hi, 32);
        chk("hsync_first", hs_first, 376);
        chk("hsync_last", hs_last, 407);
        chk("bufclr_low_count", buf_lo, 168);
        chk("lmpd_low_count", lmpd_lo, 1);
        chk("lmpd_low_at", lmpd_h, 504);
        chk("nxl_low_count", nxl_lo, 1);
        chk("nxl_low_at", nxl_h, 511);
        chk("pfhst_low_count", pf_lo, 42);
        chk("pfhst_pattern_bad", pf_bad, 0);
        chk("vrac_pattern_bad", vrac_bad, 0);
        chk("sc256_after_two_sweeps", int'(out[0]), 0);

        // Advance to h=300 (256H=1), then pulse reset between edges
        for (int v = 1; v <= 255; v++) step(8'(v));
        for (int v = 0; v <= 44; v++) step(8'(v));
        step(8'd44);
        chk("h300_out", int'(out), int'(10'b1_100_1_1_0_1_1_1));
        #1 rst_b = 1'b0;
        #1;
        chk("async_rst_sc256", int'(out[0]), 0);
        chk("async_rst_out", int'(out), LAT ? int'(10'b1_000_1_1_0_1_1_0) : int'(10'b1_100_1_1_0_1_1_0));
        #1 rst_b = 1'b1;
        m_h256 = 1'b0;
        step(8'd45);
        chk("after_rst_out", int'(out), LAT ? int'(10'b1_100_1_1_0_1_1_0) : int'(10'b1_101_1_1_0_1_1_0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
